// File: rtl/motor_pwm_driver_if.sv
// motor_pwm_driver_if
//   Bundles the seguidor_linea level commands and the L298N pin set.
//   master : command source / pin observer (ENA, IN1, ENB, IN3 driven)
//   slave  : motor_pwm_driver (commands in, bridge pins out)
//   Commands: ENA/IN1 motor A enable/direction, ENB/IN3 motor B enable/direction.
//   Pins:     pwm_a/in1_a/in2_a bridge A, pwm_b/in3_b/in4_b bridge B.
interface motor_pwm_driver_if;
    logic ENA;
    logic IN1;
    logic ENB;
    logic IN3;
    logic pwm_a;
    logic in1_a;
    logic in2_a;
    logic pwm_b;
    logic in3_b;
    logic in4_b;

    modport master (
        output ENA, IN1, ENB, IN3,
        input  pwm_a, in1_a, in2_a, pwm_b, in3_b, in4_b
    );

    modport slave (
        input  ENA, IN1, ENB, IN3,
        output pwm_a, in1_a, in2_a, pwm_b, in3_b, in4_b
    );
endinterface

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver
//   Turns level motor commands into L298N drive with a soft duty ramp and
//   safe reversal (ramp down, dead time with both direction pins low, re-drive).
//   Ports: clk, reset (async, active high), bus (motor_pwm_driver_if.slave).
//   Parameters: PWM_BITS, MAX_DUTY, RAMP_STEP, DEAD_CYCLES.
//   Optional macro MOTOR_BRAKE_EN: a channel that stops from RUN brakes
//   (pwm=in1=in2=1) until re-enabled; otherwise STOP always coasts.

// One bridge channel; both channels share the PWM counter from the top.
module motor_pwm_channel #(
    parameter int PWM_BITS    = 8,
    parameter int MAX_DUTY    = 200,
    parameter int RAMP_STEP   = 40,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] cnt_n,
    input  logic                wrap,
    input  logic                en_cmd,
    input  logic                dir_cmd,
    output logic                pwm,
    output logic                out_p,
    output logic                out_n
);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [PWM_BITS-1:0] MAX_W  = PWM_BITS'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] STEP_W = PWM_BITS'(RAMP_STEP);
    localparam logic [DW-1:0]       DEAD_W = DW'(DEAD_CYCLES);

    typedef enum logic [1:0] {STOP, RUN, RAMPDN, DEAD} state_t;

    state_t              state, state_n;
    logic                en_s1, en_s, dir_s1, dir_s;
    logic                dir, dir_n;
    logic                brake, brake_n;
    logic [PWM_BITS-1:0] duty, duty_n, target, diff, step_duty;
    logic [DW-1:0]       dead, dead_n;
    logic                drv_n, brk_n;

    always_comb begin
        state_n = state;
        dir_n   = dir;
        dead_n  = dead;
        brake_n = brake;
        case (state)
            STOP: begin
                if (en_s) begin
                    state_n = RUN;
                    dir_n   = dir_s;
                    brake_n = 1'b0;
                end
            end
            RUN: begin
                if (en_s && (dir_s != dir)) begin
                    state_n = RAMPDN;
                end else if (!en_s && (duty == '0)) begin
                    state_n = STOP;
`ifdef MOTOR_BRAKE_EN
                    brake_n = 1'b1;
`endif
                end
            end
            RAMPDN: begin
                if (duty == '0) begin
                    state_n = DEAD;
                    dead_n  = DEAD_W;
                end
            end
            DEAD: begin
                // Leaving on the clock the count would hit zero keeps the
                // direction pins low for exactly DEAD_CYCLES clocks.
                dead_n = dead - DW'(1);
                if (dead <= DW'(1)) begin
                    state_n = en_s ? RUN : STOP;
                    dir_n   = dir_s;
                    dead_n  = '0;
                end
            end
            default: state_n = STOP;
        endcase

        // Target follows the next state so a wrap coinciding with a RUN->RAMPDN
        // transition never steps the duty upward.
        target = ((state_n == RUN) && en_s) ? MAX_W : '0;

        if (target > duty) begin
            diff      = target - duty;
            step_duty = duty + ((diff > STEP_W) ? STEP_W : diff);
        end else begin
            diff      = duty - target;
            step_duty = duty - ((diff > STEP_W) ? STEP_W : diff);
        end
        duty_n = wrap ? step_duty : duty;

        drv_n = (state_n == RUN) || (state_n == RAMPDN);
        brk_n = (state_n == STOP) && brake_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_s1  <= 1'b0;
            en_s   <= 1'b0;
            dir_s1 <= 1'b0;
            dir_s  <= 1'b0;
            state  <= STOP;
            dir    <= 1'b0;
            brake  <= 1'b0;
            duty   <= '0;
            dead   <= '0;
            pwm    <= 1'b0;
            out_p  <= 1'b0;
            out_n  <= 1'b0;
        end else begin
            en_s1  <= en_cmd;
            en_s   <= en_s1;
            dir_s1 <= dir_cmd;
            dir_s  <= dir_s1;
            state  <= state_n;
            dir    <= dir_n;
            brake  <= brake_n;
            duty   <= duty_n;
            dead   <= dead_n;
            // Outputs are built from next-state values so they line up with
            // the registered counter and add only one clock to the sync delay.
            pwm    <= (drv_n && (cnt_n < duty_n)) || brk_n;
            out_p  <= (drv_n && dir_n) || brk_n;
            out_n  <= (drv_n && !dir_n) || brk_n;
        end
    end
endmodule

module motor_pwm_driver #(
    parameter int PWM_BITS    = 8,
    parameter int MAX_DUTY    = 200,
    parameter int RAMP_STEP   = 40,
    parameter int DEAD_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    motor_pwm_driver_if.slave  bus
);
    logic [PWM_BITS-1:0] cnt, cnt_n;
    logic                wrap;

    assign cnt_n = cnt + PWM_BITS'(1);
    assign wrap  = (cnt == '1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_n;
    end

    motor_pwm_channel #(
        .PWM_BITS(PWM_BITS), .MAX_DUTY(MAX_DUTY),
        .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)
    ) u_ch_a (
        .clk(clk), .reset(reset), .cnt_n(cnt_n), .wrap(wrap),
        .en_cmd(bus.ENA), .dir_cmd(bus.IN1),
        .pwm(bus.pwm_a), .out_p(bus.in1_a), .out_n(bus.in2_a)
    );

    motor_pwm_channel #(
        .PWM_BITS(PWM_BITS), .MAX_DUTY(MAX_DUTY),
        .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)
    ) u_ch_b (
        .clk(clk), .reset(reset), .cnt_n(cnt_n), .wrap(wrap),
        .en_cmd(bus.ENB), .dir_cmd(bus.IN3),
        .pwm(bus.pwm_b), .out_p(bus.in3_b), .out_n(bus.in4_b)
    );
endmodule

// File: tb/tb_motor_pwm_driver.sv
// Testbench for motor_pwm_driver. Per-PWM-period records (high counts of
// pwm and both direction pins, per channel) are expected from a queue and
// compared by a monitor as each period completes.
module tb_motor_pwm_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tick;
    int   tests  = 0;
    int   failed = 0;

    typedef struct {
        int    period;
        string tag;
        int    v[6];   // a_pwm, a_in1, a_in2, b_pwm, b_in3, b_in4
    } rec_t;

    rec_t exp_q[$];

    motor_pwm_driver_if bus();

    motor_pwm_driver #(
        .PWM_BITS(8), .MAX_DUTY(200), .RAMP_STEP(40), .DEAD_CYCLES(16)
    ) dut (
        .clk(clk), .reset(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Posedges since the last reset release; equals the DUT counter value.
    always @(posedge clk or posedge rst) begin
        if (rst) tick <= 0;
        else     tick <= tick + 1;
    end

    task automatic cmp(string name, int act, int expv);
        tests++;
        if (act != expv) begin
            failed++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic push(string tag, int p, int ah, int a1, int a2, int bh, int b1, int b2);
        rec_t r;
        r.period = p;
        r.tag    = tag;
        r.v[0] = ah; r.v[1] = a1; r.v[2] = a2;
        r.v[3] = bh; r.v[4] = b1; r.v[5] = b2;
        exp_q.push_back(r);
    endtask

    // Monitor: accumulate pin high-counts over each 256-clock period.
    initial begin : monitor
        int acc[6];
        string fld[6];
        fld[0] = "pwm_a"; fld[1] = "in1_a"; fld[2] = "in2_a";
        fld[3] = "pwm_b"; fld[4] = "in3_b"; fld[5] = "in4_b";
        for (int i = 0; i < 6; i++) acc[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < 6; i++) acc[i] = 0;
            end else begin
                acc[0] += int'(bus.pwm_a);
                acc[1] += int'(bus.in1_a);
                acc[2] += int'(bus.in2_a);
                acc[3] += int'(bus.pwm_b);
                acc[4] += int'(bus.in3_b);
                acc[5] += int'(bus.in4_b);
                if ((tick % 256) == 255) begin
                    while (exp_q.size() > 0 && exp_q[0].period < tick / 256) begin
                        tests++;
                        failed++;
                        $display("FAIL %s period %0d not observed actual=none expected=record",
                                 exp_q[0].tag, exp_q[0].period);
                        void'(exp_q.pop_front());
                    end
                    if (exp_q.size() > 0 && exp_q[0].period == tick / 256) begin
                        rec_t r;
                        r = exp_q.pop_front();
                        for (int i = 0; i < 6; i++)
                            cmp($sformatf("%s.P%0d.%s", r.tag, r.period, fld[i]), acc[i], r.v[i]);
                    end
                    for (int i = 0; i < 6; i++) acc[i] = 0;
                end
            end
        end
    end

    task automatic wait_until(int k);
        while (tick < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL %s drain timeout actual=%0d expected=0 pending", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pins_zero(string tag);
        cmp({tag, ".pwm_a"}, int'(bus.pwm_a), 0);
        cmp({tag, ".in1_a"}, int'(bus.in1_a), 0);
        cmp({tag, ".in2_a"}, int'(bus.in2_a), 0);
        cmp({tag, ".pwm_b"}, int'(bus.pwm_b), 0);
        cmp({tag, ".in3_b"}, int'(bus.in3_b), 0);
        cmp({tag, ".in4_b"}, int'(bus.in4_b), 0);
    endtask

    // Leaves reset deasserted 1 time unit after a posedge (tick == 0).
    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset held with both enables active: all pins must stay low.
        bus.ENA = 1'b1; bus.IN1 = 1'b1; bus.ENB = 1'b1; bus.IN3 = 1'b1;
        repeat (5) @(posedge clk);
        #1 pins_zero("reset_hold");
        bus.ENA = 1'b0; bus.ENB = 1'b0;
        rst = 1'b0;
        for (int p = 0; p < 4; p++) push("idle", p, 0, 0, 0, 0, 0, 0);
        wait_until(1024);
        drain("idle");

        // Forward ramp, reversal with dead time, then stop.
        do_reset();
        bus.ENA = 1'b1; bus.IN1 = 1'b1;
        push("fwd", 0, 0, 253, 0, 0, 0, 0);
        push("fwd", 1, 40, 256, 0, 0, 0, 0);
        push("fwd", 2, 80, 256, 0, 0, 0, 0);
        push("fwd", 3, 120, 256, 0, 0, 0, 0);
        push("fwd", 4, 160, 256, 0, 0, 0, 0);
        push("fwd", 5, 200, 256, 0, 0, 0, 0);
        push("fwd", 6, 200, 256, 0, 0, 0, 0);
        push("rev", 7, 160, 256, 0, 0, 0, 0);
        push("rev", 8, 120, 256, 0, 0, 0, 0);
        push("rev", 9, 80, 256, 0, 0, 0, 0);
        push("rev", 10, 40, 256, 0, 0, 0, 0);
        push("rev_dead", 11, 0, 1, 239, 0, 0, 0);
        push("rev", 12, 40, 0, 256, 0, 0, 0);
        push("rev", 13, 80, 0, 256, 0, 0, 0);
        push("rev", 14, 120, 0, 256, 0, 0, 0);
        push("rev", 15, 160, 0, 256, 0, 0, 0);
        push("rev", 16, 200, 0, 256, 0, 0, 0);
        push("stop", 17, 200, 0, 256, 0, 0, 0);
        push("stop", 18, 160, 0, 256, 0, 0, 0);
        push("stop", 19, 120, 0, 256, 0, 0, 0);
        push("stop", 20, 80, 0, 256, 0, 0, 0);
        push("stop", 21, 40, 0, 256, 0, 0, 0);
`ifdef MOTOR_BRAKE_EN
        push("brake", 22, 255, 255, 256, 0, 0, 0);
        push("brake", 23, 256, 256, 256, 0, 0, 0);
`else
        push("coast", 22, 0, 0, 1, 0, 0, 0);
        push("coast", 23, 0, 0, 0, 0, 0, 0);
`endif
        wait_until(1536);
        bus.IN1 = 1'b0;
        wait_until(4352);
        bus.ENA = 1'b0;
        wait_until(6144);
        drain("fwd_rev_stop");

        // Reset pulse in the duty-120 period, then the ramp restarts.
        do_reset();
        bus.ENA = 1'b1; bus.IN1 = 1'b1;
        push("pre_rst", 0, 0, 253, 0, 0, 0, 0);
        push("pre_rst", 1, 40, 256, 0, 0, 0, 0);
        push("pre_rst", 2, 80, 256, 0, 0, 0, 0);
        wait_until(868);
        drain("pre_rst");
        rst = 1'b1;
        #1 pins_zero("reset_mid");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push("post_rst", 0, 0, 253, 0, 0, 0, 0);
        push("post_rst", 1, 40, 256, 0, 0, 0, 0);
        push("post_rst", 2, 80, 256, 0, 0, 0, 0);
        wait_until(768);
        drain("post_rst");

        // Enable drops for one wrap at duty 120: 80 then back up, never stopping.
        do_reset();
        bus.ENA = 1'b1; bus.IN1 = 1'b1;
        push("reen", 0, 0, 253, 0, 0, 0, 0);
        push("reen", 1, 40, 256, 0, 0, 0, 0);
        push("reen", 2, 80, 256, 0, 0, 0, 0);
        push("reen", 3, 120, 256, 0, 0, 0, 0);
        push("reen", 4, 80, 256, 0, 0, 0, 0);
        push("reen", 5, 120, 256, 0, 0, 0, 0);
        push("reen", 6, 160, 256, 0, 0, 0, 0);
        wait_until(1000);
        bus.ENA = 1'b0;
        wait_until(1100);
        bus.ENA = 1'b1;
        wait_until(1792);
        drain("reen");

        // Channel B reversal with IN3 toggled through the dead time;
        // last sampled value (1) decides the exit direction.
        do_reset();
        bus.ENA = 1'b0; bus.IN1 = 1'b0;
        bus.ENB = 1'b1; bus.IN3 = 1'b1;
        push("storm", 0, 0, 0, 0, 0, 253, 0);
        push("storm", 1, 0, 0, 0, 40, 256, 0);
        push("storm", 2, 0, 0, 0, 0, 240, 0);
        push("storm", 3, 0, 0, 0, 40, 256, 0);
        wait_until(256);
        bus.IN3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_until(506 + 5 * k);
            bus.IN3 = ~bus.IN3;
        end
        wait_until(1024);
        drain("storm");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
